// File: rtl/cpu_pc_ctrl.sv
// cpu_pc_ctrl: program counter and branch controller.
// Each enabled cycle picks the next fetch address from PC+1, TARGET, or the
// top of a small return-address stack. Conditional jumps test a single
// registered flag (C, Z or B). Stack overflow and underflow are sticky.
module cpu_pc_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [2:0]        OP,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic              C,
  input  logic              Z,
  input  logic              B,
  output logic [ADDR_W-1:0] PC,
  output logic              TAKEN,
  output logic [SP_W-1:0]   SP,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  // Stack index width. Depth 1 still needs a 1-bit index. The array is
  // rounded up to a power of two so every index value is in range.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 2 ** IDX_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_JC   = 3'b010,
    OP_JZ   = 3'b011,
    OP_JB   = 3'b100,
    OP_CALL = 3'b101,
    OP_RET  = 3'b110,
    OP_HOLD = 3'b111
  } op_e;

  op_e op;
  assign op = op_e'(OP);

  // Return-address storage. Its contents are not cleared on reset: SP=0
  // already marks every entry as invalid.
  logic [ADDR_W-1:0] stack [SLOTS];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              stk_full;
  logic              stk_empty;

  // The increment wraps naturally at ADDR_W bits, so a CALL from the last
  // address pushes 0.
  assign pc_inc    = PC + 1'b1;
  assign push_idx  = IDX_W'(SP);
  assign pop_idx   = IDX_W'(SP - 1'b1);
  assign stack_top = stack[pop_idx];
  assign stk_full  = (SP == SP_FULL);
  assign stk_empty = (SP == '0);

  logic [ADDR_W-1:0] pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              taken_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;

  // Next-state selection for one op. Flags are the values presented before
  // the edge, so a flag written on the same edge only affects the next op.
  always_comb begin
    pc_nxt    = pc_inc;
    sp_nxt    = SP;
    taken_nxt = 1'b0;
    ovf_nxt   = STK_OVF;
    unf_nxt   = STK_UNF;
    push      = 1'b0;
    unique case (op)
      OP_NEXT: ;
      OP_JMP: begin
        pc_nxt    = TARGET;
        taken_nxt = 1'b1;
      end
      OP_JC: if (C) begin
        pc_nxt    = TARGET;
        taken_nxt = 1'b1;
      end
      OP_JZ: if (Z) begin
        pc_nxt    = TARGET;
        taken_nxt = 1'b1;
      end
      OP_JB: if (B) begin
        pc_nxt    = TARGET;
        taken_nxt = 1'b1;
      end
      OP_CALL: begin
        if (stk_full) begin
          // No push and no jump; execution falls through.
          ovf_nxt = 1'b1;
        end else begin
          push      = 1'b1;
          sp_nxt    = SP + 1'b1;
          pc_nxt    = TARGET;
          taken_nxt = 1'b1;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          unf_nxt = 1'b1;
        end else begin
          sp_nxt    = SP - 1'b1;
          pc_nxt    = stack_top;
          taken_nxt = 1'b1;
        end
      end
      OP_HOLD: pc_nxt = PC;
      default: ;
    endcase
  end

  // Architectural state. Reset clears everything at once without a clock,
  // which drops any pending return addresses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PC      <= '0;
      SP      <= '0;
      TAKEN   <= 1'b0;
      STK_OVF <= 1'b0;
      STK_UNF <= 1'b0;
    end else if (EN) begin
      PC      <= pc_nxt;
      SP      <= sp_nxt;
      TAKEN   <= taken_nxt;
      STK_OVF <= ovf_nxt;
      STK_UNF <= unf_nxt;
    end
  end

  // Push the wrapped return address on a successful CALL.
  always_ff @(posedge CLK) begin
    if (RST && EN && push) stack[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// Directed-vector bench for cpu_pc_ctrl. The driver issues one op per cycle
// and queues the hand-computed state expected after that edge. A separate
// monitor pops the queue after each rising edge, or immediately after an
// asynchronous reset event, and compares the queued state with the DUT.
module tb_cpu_pc_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);

  localparam logic [2:0] NEXT = 3'b000, JMP = 3'b001, JC = 3'b010, JZ = 3'b011;
  localparam logic [2:0] JB = 3'b100, CALL = 3'b101, RET = 3'b110, HOLD = 3'b111;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              EN  = 1'b0;
  logic [2:0]        OP  = 3'b000;
  logic [ADDR_W-1:0] TARGET = '0;
  logic              C = 1'b0, Z = 1'b0, B = 1'b0;
  logic [ADDR_W-1:0] PC;
  logic              TAKEN;
  logic [SP_W-1:0]   SP;
  logic              STK_OVF, STK_UNF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              unf;
  } obs_t;

  obs_t  exp_q  [$];
  string name_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  event  chk_now;

  cpu_pc_ctrl #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .OP(OP), .TARGET(TARGET),
    .C(C), .Z(Z), .B(B),
    .PC(PC), .TAKEN(TAKEN), .SP(SP), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  // Monitor: sample 1 time unit after each rising edge, or after an
  // immediate-check event, and drain whatever the driver queued.
  initial begin
    obs_t  e, a;
    string nm;
    forever begin
      @(posedge CLK or chk_now);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{pc: PC, taken: TAKEN, sp: SP, ovf: STK_OVF, unf: STK_UNF};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got pc=%h taken=%b sp=%0d ovf=%b unf=%b, want pc=%h taken=%b sp=%0d ovf=%b unf=%b",
                   nm, a.pc, a.taken, a.sp, a.ovf, a.unf, e.pc, e.taken, e.sp, e.ovf, e.unf);
        end
      end
    end
  end

  task automatic expect_state(input string nm, input logic [7:0] pc, input logic tk,
                              input int sp, input logic ovf, input logic unf);
    exp_q.push_back('{pc: pc, taken: tk, sp: SP_W'(sp), ovf: ovf, unf: unf});
    name_q.push_back(nm);
  endtask

  // Drive one op at the falling edge; the result is checked after the next
  // rising edge.
  task automatic step(input string nm, input logic en, input logic [2:0] op,
                      input logic [7:0] tgt, input logic [2:0] czb,
                      input logic [7:0] pc, input logic tk, input int sp,
                      input logic ovf, input logic unf);
    @(negedge CLK);
    EN = en; OP = op; TARGET = tgt; {C, Z, B} = czb;
    expect_state(nm, pc, tk, sp, ovf, unf);
  endtask

  initial begin
    // Reset state, checked while reset is held.
    #2;
    expect_state("reset", 8'h00, 0, 0, 0, 0);
    ->chk_now;
    @(negedge CLK);
    RST = 1'b1;

    // Sequential fetch, then wrap from 0xFF.
    step("next1", 1, NEXT, 8'h00, 3'b000, 8'h01, 0, 0, 0, 0);
    step("next2", 1, NEXT, 8'h00, 3'b000, 8'h02, 0, 0, 0, 0);
    step("next3", 1, NEXT, 8'h00, 3'b000, 8'h03, 0, 0, 0, 0);
    step("next4", 1, NEXT, 8'h00, 3'b000, 8'h04, 0, 0, 0, 0);
    step("next5", 1, NEXT, 8'h00, 3'b000, 8'h05, 0, 0, 0, 0);
    step("jmp_ff", 1, JMP, 8'hFF, 3'b000, 8'hFF, 1, 0, 0, 0);
    step("wrap",   1, NEXT, 8'h00, 3'b000, 8'h00, 0, 0, 0, 0);

    // Conditional jumps; each condition ignores the other two flags.
    step("jc_nt", 1, JC, 8'h40, 3'b011, 8'h01, 0, 0, 0, 0);
    step("jc_t",  1, JC, 8'h40, 3'b100, 8'h40, 1, 0, 0, 0);
    step("jz_nt", 1, JZ, 8'h40, 3'b101, 8'h41, 0, 0, 0, 0);
    step("jz_t",  1, JZ, 8'h40, 3'b010, 8'h40, 1, 0, 0, 0);
    step("jb_nt", 1, JB, 8'h40, 3'b110, 8'h41, 0, 0, 0, 0);
    step("jb_t",  1, JB, 8'h40, 3'b001, 8'h40, 1, 0, 0, 0);

    // Call/return nesting.
    step("jmp_10", 1, JMP,  8'h10, 3'b000, 8'h10, 1, 0, 0, 0);
    step("call80", 1, CALL, 8'h80, 3'b000, 8'h80, 1, 1, 0, 0);
    step("callA0", 1, CALL, 8'hA0, 3'b000, 8'hA0, 1, 2, 0, 0);
    step("ret81",  1, RET,  8'h00, 3'b000, 8'h81, 1, 1, 0, 0);
    step("ret11",  1, RET,  8'h00, 3'b000, 8'h11, 1, 0, 0, 0);

    // EN=0 freezes everything, including TAKEN; HOLD keeps PC and clears TAKEN.
    step("en0_jmp",  0, JMP,  8'h77, 3'b111, 8'h11, 1, 0, 0, 0);
    step("hold",     1, HOLD, 8'h77, 3'b000, 8'h11, 0, 0, 0, 0);
    step("en0_next", 0, NEXT, 8'h00, 3'b000, 8'h11, 0, 0, 0, 0);

    // Fill the stack, overflow, then unwind in LIFO order and underflow.
    step("fill1", 1, CALL, 8'h20, 3'b000, 8'h20, 1, 1, 0, 0);
    step("fill2", 1, CALL, 8'h21, 3'b000, 8'h21, 1, 2, 0, 0);
    step("fill3", 1, CALL, 8'h22, 3'b000, 8'h22, 1, 3, 0, 0);
    step("fill4", 1, CALL, 8'h30, 3'b000, 8'h30, 1, 4, 0, 0);
    step("ovf",   1, CALL, 8'h99, 3'b000, 8'h31, 0, 4, 1, 0);
    step("ovf_k1", 1, NEXT, 8'h00, 3'b000, 8'h32, 0, 4, 1, 0);
    step("ovf_k2", 1, NEXT, 8'h00, 3'b000, 8'h33, 0, 4, 1, 0);
    step("pop4",  1, RET, 8'h00, 3'b000, 8'h23, 1, 3, 1, 0);
    step("pop3",  1, RET, 8'h00, 3'b000, 8'h22, 1, 2, 1, 0);
    step("pop2",  1, RET, 8'h00, 3'b000, 8'h21, 1, 1, 1, 0);
    step("pop1",  1, RET, 8'h00, 3'b000, 8'h12, 1, 0, 1, 0);
    step("unf",   1, RET, 8'h00, 3'b000, 8'h13, 0, 0, 1, 1);
    step("unf_k", 1, NEXT, 8'h00, 3'b000, 8'h14, 0, 0, 1, 1);

    // A CALL from the last address pushes 0.
    step("jmp_ff2",  1, JMP,  8'hFF, 3'b000, 8'hFF, 1, 0, 1, 1);
    step("call_wr",  1, CALL, 8'h50, 3'b000, 8'h50, 1, 1, 1, 1);
    step("ret_wr",   1, RET,  8'h00, 3'b000, 8'h00, 1, 0, 1, 1);

    // Asynchronous reset mid call chain: SP=2 and PC=0x55 beforehand.
    step("pre_c1", 1, CALL, 8'h60, 3'b000, 8'h60, 1, 1, 1, 1);
    step("pre_c2", 1, CALL, 8'h55, 3'b000, 8'h55, 1, 2, 1, 1);
    @(negedge CLK);
    EN = 1'b0;
    #2;
    RST = 1'b0;
    expect_state("async_rst", 8'h00, 0, 0, 0, 0);
    ->chk_now;
    @(negedge CLK);
    RST = 1'b1;
    step("post_next", 1, NEXT, 8'h00, 3'b000, 8'h01, 0, 0, 0, 0);
    step("post_ret",  1, RET,  8'h00, 3'b000, 8'h02, 0, 0, 0, 1);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_pc_ctrl.md
# cpu_pc_ctrl

Program-counter and branch controller for the one-cycle CPU, sitting directly downstream of the flag register. Each clock it selects the next instruction address from PC+1, an absolute target, or a return address popped from a small internal call stack. Conditional jumps are resolved against the registered Carry, Zero and Borrow flags. It produces the fetch address for program memory and reports stack errors.

## Interface
- ADDR_W, 8, width of program address, PC and TARGET
- STACK_DEPTH, 4, number of return-address entries (≥1)
- SP_W, $clog2(STACK_DEPTH+1), width of SP output
- CLK  in  1  system clock, rising-edge active
- RST  in  1  asynchronous, active-low reset
- EN  in  1  advance enable; when 0, no state changes
- OP  in  3  control op: 000 NEXT, 001 JMP, 010 JC, 011 JZ, 100 JB, 101 CALL, 110 RET, 111 HOLD
- TARGET  in  ADDR_W  absolute jump/call address
- C  in  1  carry flag from flag register
- Z  in  1  zero flag from flag register
- B  in  1  borrow flag from flag register
- PC  out  ADDR_W  current fetch address
- TAKEN  out  1  registered; 1 for the cycle after a redirect (JMP, taken Jcc, CALL, RET)
- SP  out  SP_W  number of valid stack entries
- STK_OVF  out  1  sticky: CALL attempted with stack full
- STK_UNF  out  1  sticky: RET attempted with stack empty

## Operation
- Reset (RST=0, asynchronous): PC=0, SP=0, TAKEN=0, STK_OVF=0, STK_UNF=0. Stack contents are don't-care.
- All updates happen on the rising CLK edge with EN=1 and RST=1. With EN=0 every register holds, including TAKEN.
- Per-op next state, where PC+1 wraps 2^ADDR_W−1 → 0:
  - NEXT: PC←PC+1, TAKEN←0.
  - JMP: PC←TARGET, TAKEN←1.
  - JC / JZ / JB: if C / Z / B = 1 then PC←TARGET, TAKEN←1; else PC←PC+1, TAKEN←0.
  - CALL, SP<STACK_DEPTH: stack[SP]←PC+1 (wrapped), SP←SP+1, PC←TARGET, TAKEN←1.
  - CALL, SP=STACK_DEPTH (full): no push, no jump, PC←PC+1, TAKEN←0, STK_OVF←1.
  - RET, SP>0: PC←stack[SP−1], SP←SP−1, TAKEN←1.
  - RET, SP=0 (empty): PC←PC+1, TAKEN←0, STK_UNF←1.
  - HOLD: PC, SP and stack unchanged, TAKEN←0.
- Flags are sampled in the same cycle as the op, as presented by the flag register's outputs before the edge. A flag updated on the same edge affects only the next instruction.
- Only C, Z and B are examined. Conditions are single-flag; there are no negated forms.
- STK_OVF and STK_UNF clear only on reset.
- A CALL whose return address wraps (PC = 2^ADDR_W−1) pushes 0.

## Timing
- Latency: the op in cycle n determines PC in cycle n+1. PC is a pure register output with no combinational path from inputs.
- TAKEN, SP, STK_OVF and STK_UNF are registered and change on the same edge as PC.
- No handshake; one op is consumed per enabled cycle.
- If reset is asserted mid-call-chain, all return addresses are lost and SP=0 immediately, without waiting for a clock edge.
- Deassertion of RST is synchronised externally; the block only requires RST stable around the CLK edge.

## Test plan
- Reset and sequential fetch: RST=0, then RST=1, EN=1, OP=NEXT for 5 cycles → PC steps 0,1,2,3,4,5; TAKEN=0; SP=0. With ADDR_W=8, from PC=255 NEXT → PC=0.
- Conditional jumps: TARGET=0x40; JC with C=0 → PC+1, TAKEN=0; JC with C=1 → PC=0x40, TAKEN=1 next cycle. Repeat for JZ/Z and JB/B, checking each condition ignores the other two flags.
- Call/return nesting: from PC=0x10, CALL 0x80; from PC=0x80, CALL 0xA0; then RET, RET → PC sequence 0x80, 0xA0, 0x81, 0x11; SP sequence 1, 2, 1, 0; TAKEN=1 on each redirect.
- Stack full: 4 CALLs then a 5th CALL from PC=0x30 → PC=0x31, SP=4, STK_OVF=1, which persists through later NEXT ops. Four RETs return in LIFO order; a 5th RET → PC+1, STK_UNF=1.
- EN and HOLD: EN=0 with OP=JMP → no change in PC, SP or TAKEN. OP=HOLD with EN=1 → PC unchanged, TAKEN=0.
- Asynchronous reset mid-operation: with SP=2 and PC=0x55, drive RST=0 between clock edges → PC=0, SP=0, TAKEN=0 and both sticky flags 0 immediately, before the next CLK edge.
